// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and the hazard controller.
// The pipeline side is the master; hazard_ctrl is the slave.
interface hazard_ctrl_if;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RsE;
    logic [4:0]  RtE;
    logic [4:0]  WriteRegE;
    logic [4:0]  WriteRegM;
    logic [4:0]  WriteRegW;
    logic        RegWriteE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        MemReadE;
    logic        MemToRegM;
    logic        BranchD;
    logic        PCSrcD;
    logic        SyscallD;
    logic        syscall_done;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        ForwardAD;
    logic        ForwardBD;
    logic        syscall_go;
    logic        syscall_err;
    logic [15:0] stall_cnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemReadE, MemToRegM,
               BranchD, PCSrcD, SyscallD, syscall_done,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, syscall_go, syscall_err, stall_cnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemReadE, MemToRegM,
               BranchD, PCSrcD, SyscallD, syscall_done,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, syscall_go, syscall_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and flush control for the 5-stage MIPS pipeline, plus the
// syscall drain / service hand-off / resume sequence.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned SVC_TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    // state    | meaning
    // RUN      | normal issue; hazard stalls and taken-branch flushes
    // DRAIN    | syscall accepted, inserting bubbles
    // WAIT_SVC | pipeline empty, service logic owns the machine
    // RESUME   | one-cycle flush, then back to RUN
    typedef enum logic [1:0] {RUN, DRAIN, WAIT_SVC, RESUME} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(SVC_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        lwstall, brstall, haz;
    logic        stall, flush_d, flush_e, go;
    logic [1:0]  fwd_ae, fwd_be;
    logic        fwd_ad, fwd_bd;

    always_comb begin
        fwd_ae = 2'b00;
        if (hz.RsE != 5'd0 && hz.RegWriteM && hz.WriteRegM == hz.RsE)
            fwd_ae = 2'b10;
        else if (hz.RsE != 5'd0 && hz.RegWriteW && hz.WriteRegW == hz.RsE)
            fwd_ae = 2'b01;

        fwd_be = 2'b00;
        if (hz.RtE != 5'd0 && hz.RegWriteM && hz.WriteRegM == hz.RtE)
            fwd_be = 2'b10;
        else if (hz.RtE != 5'd0 && hz.RegWriteW && hz.WriteRegW == hz.RtE)
            fwd_be = 2'b01;

        fwd_ad = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
        fwd_bd = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);
    end

    assign lwstall = hz.MemReadE && (hz.RtE != 5'd0) &&
                     ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

    // The branch comparator in decode needs both an ALU result still in execute
    // and a load result still in memory to have landed first.
    assign brstall = hz.BranchD &&
                     ((hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                       ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                      (hz.MemToRegM && (hz.WriteRegM != 5'd0) &&
                       ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));

    assign haz = lwstall || brstall;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        stall   = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        go      = 1'b0;
        case (state_q)
            RUN: begin
                stall   = haz;
                flush_e = haz;
                flush_d = hz.PCSrcD && !haz;
                if (hz.SyscallD && !haz) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                stall   = 1'b1;
                flush_e = 1'b1;
                if (drain_q == 4'd0) begin
                    state_d = WAIT_SVC;
                    tmo_d   = 8'd0;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            WAIT_SVC: begin
                stall   = 1'b1;
                flush_e = 1'b1;
                // tmo_q is zero only on the first WAIT_SVC cycle
                go      = (tmo_q == 8'd0);
                tmo_d   = tmo_q + 8'd1;
                if (hz.syscall_done) begin
                    state_d = RESUME;
                    err_d   = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RESUME;
                    err_d   = 1'b1;
                end
            end
            RESUME: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign cnt_d = (hz.StallD && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= 4'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.StallF      = rst_n && stall;
    assign hz.StallD      = rst_n && stall;
    assign hz.FlushD      = rst_n && flush_d;
    assign hz.FlushE      = !rst_n || flush_e;
    assign hz.ForwardAE   = rst_n ? fwd_ae : 2'b00;
    assign hz.ForwardBE   = rst_n ? fwd_be : 2'b00;
    assign hz.ForwardAD   = rst_n && fwd_ad;
    assign hz.ForwardBD   = rst_n && fwd_bd;
    assign hz.syscall_go  = rst_n && go;
    assign hz.syscall_err = err_q;
    assign hz.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-age based reference model.
module tb_hazard_ctrl;
    localparam int D = 3;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(.DRAIN_CYCLES(D), .SVC_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a syscall is tracked by its age in cycles since accept.
    int m_busy = 0;
    int m_age  = 0;
    int m_res  = -1;
    int m_err  = 0;
    int m_cnt  = 0;
    int ph;
    logic lw_m, br_m, haz_m;
    logic e_stall, e_flushd, e_flushe, e_go, e_fad, e_fbd;
    logic [1:0] e_fae, e_fbe;

    function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic rwm,
                                         input logic [4:0] wrm, input logic rww,
                                         input logic [4:0] wrw);
        if (src == 0) return 2'b00;
        if (rwm && wrm == src) return 2'b10;
        if (rww && wrw == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        lw_m  = hz.MemReadE && hz.RtE != 0 && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
        br_m  = hz.BranchD &&
                ((hz.RegWriteE && hz.WriteRegE != 0 &&
                  (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                 (hz.MemToRegM && hz.WriteRegM != 0 &&
                  (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
        haz_m = lw_m || br_m;
        if (m_busy == 0)     ph = 0;
        else if (m_age <= D) ph = 1;
        else if (m_age == m_res) ph = 3;
        else                 ph = 2;
        e_stall  = 1'b0;
        e_flushd = 1'b0;
        e_flushe = 1'b0;
        e_go     = 1'b0;
        case (ph)
            0: begin
                e_stall  = haz_m;
                e_flushe = haz_m;
                e_flushd = hz.PCSrcD && !haz_m;
            end
            1: begin e_stall = 1'b1; e_flushe = 1'b1; end
            2: begin e_stall = 1'b1; e_flushe = 1'b1; e_go = (m_age == D + 1); end
            default: begin e_flushd = 1'b1; e_flushe = 1'b1; end
        endcase
        e_fae = fwd_e(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        e_fbe = fwd_e(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        e_fad = hz.RsD != 0 && hz.RegWriteM && hz.WriteRegM == hz.RsD;
        e_fbd = hz.RtD != 0 && hz.RegWriteM && hz.WriteRegM == hz.RtD;
        if (!rst_n) begin
            e_stall = 1'b0; e_flushd = 1'b0; e_flushe = 1'b1; e_go = 1'b0;
            e_fae = 2'b00; e_fbe = 2'b00; e_fad = 1'b0; e_fbd = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 0; m_age <= 0; m_res <= -1; m_err <= 0; m_cnt <= 0;
        end else begin
            if (e_stall && m_cnt < 65535) m_cnt <= m_cnt + 1;
            case (ph)
                0: if (hz.SyscallD && !haz_m) begin
                    m_busy <= 1; m_age <= 1; m_res <= -1;
                end
                1: m_age <= m_age + 1;
                2: begin
                    m_age <= m_age + 1;
                    if (hz.syscall_done) begin
                        m_res <= m_age + 1; m_err <= 0;
                    end else if (m_age == D + T) begin
                        m_res <= m_age + 1; m_err <= 1;
                    end
                end
                default: m_busy <= 0;
            endcase
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemReadE = 0; hz.MemToRegM = 0; hz.BranchD = 0; hz.PCSrcD = 0;
        hz.SyscallD = 0; hz.syscall_done = 0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst_n = 1'b0;
        idle_inputs();
        hz.RsE = 8; hz.RtE = 8; hz.RsD = 8; hz.RtD = 8;
        hz.RegWriteM = 1; hz.WriteRegM = 8; hz.MemReadE = 1; hz.PCSrcD = 1;
        @(negedge clk);
        n_chk++;
        if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00010",
                     {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go});
        end
        n_chk++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_fwd: got %b expected 000000",
                     {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD});
        end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE, hz.syscall_err} !== 3'b000 || hz.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_release: got stall/flushE/err %b cnt %0d expected 000 cnt 0",
                     {hz.StallD, hz.FlushE, hz.syscall_err}, hz.stall_cnt);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        hz.MemReadE = 1; hz.RtE = 5; hz.RsD = 5;
        @(negedge clk);
        n_chk++;
        if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b1110) begin
            n_fail++;
            $display("FAIL loaduse_stall: got %b expected 1110",
                     {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (hz.StallD !== 1'b0 || hz.stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL loaduse_cnt: got stall %b cnt %0d expected 0 cnt 1", hz.StallD, hz.stall_cnt);
        end
        next_cycle();
        hz.MemReadE = 1; hz.RtE = 0; hz.RsD = 0;
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE} !== 2'b00) begin
            n_fail++;
            $display("FAIL loaduse_r0: got %b expected 00", {hz.StallD, hz.FlushE});
        end
        next_cycle();
        hz.MemReadE = 1; hz.RtE = 7; hz.RtD = 7; hz.RsD = 2;
        @(negedge clk);
        n_chk++;
        if (hz.StallD !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_rt: got %b expected 1", hz.StallD);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (hz.stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL loaduse_cnt2: got %0d expected 2", hz.stall_cnt);
        end
    endtask

    task automatic test_forward();
        next_cycle();
        hz.RsE = 8; hz.RegWriteM = 1; hz.WriteRegM = 8; hz.RegWriteW = 1; hz.WriteRegW = 8;
        @(negedge clk);
        n_chk++;
        if (hz.ForwardAE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_prio_mem: got %b expected 10", hz.ForwardAE);
        end
        next_cycle();
        hz.RegWriteM = 0;
        @(negedge clk);
        n_chk++;
        if (hz.ForwardAE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_wb: got %b expected 01", hz.ForwardAE);
        end
        next_cycle();
        idle_inputs();
        hz.RsE = 0; hz.RegWriteW = 1; hz.WriteRegW = 0; hz.RtE = 9;
        hz.RegWriteM = 1; hz.WriteRegM = 4; hz.RsD = 4; hz.RtD = 4;
        @(negedge clk);
        n_chk++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 6'b000011) begin
            n_fail++;
            $display("FAIL fwd_r0_dec: got %b expected 000011",
                     {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD});
        end
        next_cycle();
        hz.WriteRegW = 9; hz.RsD = 0; hz.RtD = 5;
        @(negedge clk);
        n_chk++;
        if ({hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !== 4'b0100) begin
            n_fail++;
            $display("FAIL fwd_be_wb: got %b expected 0100", {hz.ForwardBE, hz.ForwardAD, hz.ForwardBD});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_branch();
        next_cycle();
        hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 3; hz.RtD = 3; hz.PCSrcD = 1;
        @(negedge clk);
        n_chk++;
        if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b1110) begin
            n_fail++;
            $display("FAIL branch_stall: got %b expected 1110",
                     {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD});
        end
        next_cycle();
        hz.RegWriteE = 0;
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE, hz.FlushD} !== 3'b001) begin
            n_fail++;
            $display("FAIL branch_taken: got %b expected 001", {hz.StallD, hz.FlushE, hz.FlushD});
        end
        next_cycle();
        idle_inputs();
        hz.BranchD = 1; hz.MemToRegM = 1; hz.WriteRegM = 2; hz.RsD = 2;
        @(negedge clk);
        n_chk++;
        if (hz.StallD !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_load: got %b expected 1", hz.StallD);
        end
        next_cycle();
        idle_inputs();
        hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 0; hz.RsD = 0;
        @(negedge clk);
        n_chk++;
        if (hz.StallD !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_r0: got %b expected 0", hz.StallD);
        end
        next_cycle();
        idle_inputs();
    endtask

    // Cycle 0 presents SyscallD; done_at < 0 means no completion (timeout path).
    task automatic run_syscall(input string name, input int done_at, input int ncyc);
        int end_wait;
        int err_exp;
        end_wait = (done_at < 0) ? D + T : done_at;
        err_exp  = (done_at < 0) ? 1 : 0;
        next_cycle();
        idle_inputs();
        hz.SyscallD = 1;
        @(negedge clk);
        n_chk++;
        if (hz.StallD !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_c0: got stall %b expected 0", name, hz.StallD);
        end
        for (int c = 1; c <= ncyc; c++) begin
            next_cycle();
            hz.SyscallD = 0;
            hz.syscall_done = (c == done_at) || (c == 2);
            @(negedge clk);
            n_chk++;
            if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go} !==
                {c <= end_wait, c <= end_wait, c == end_wait + 1,
                 c <= end_wait + 1, c == D + 1}) begin
                n_fail++;
                $display("FAIL %s_c%0d: got %b expected %b", name, c,
                         {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go},
                         {c <= end_wait, c <= end_wait, c == end_wait + 1,
                          c <= end_wait + 1, c == D + 1});
            end
            if (c > end_wait) begin
                n_chk++;
                if (hz.syscall_err !== err_exp[0]) begin
                    n_fail++;
                    $display("FAIL %s_err_c%0d: got %b expected %0d", name, c, hz.syscall_err, err_exp);
                end
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_syscall();
        run_syscall("syscall", 6, 8);
    endtask

    task automatic test_timeout();
        run_syscall("timeout", -1, 9);
        run_syscall("after_tmo", 6, 8);
    endtask

    task automatic test_syscall_hazard();
        next_cycle();
        hz.SyscallD = 1; hz.MemReadE = 1; hz.RtE = 6; hz.RsD = 6;
        @(negedge clk);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE} !== 2'b00) begin
            n_fail++;
            $display("FAIL syscall_haz: got %b expected 00", {hz.StallD, hz.FlushE});
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        idle_inputs();
        hz.SyscallD = 1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            hz.SyscallD = 0;
        end
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE, hz.syscall_go} !== 3'b010) begin
            n_fail++;
            $display("FAIL rstwait_low: got %b expected 010", {hz.StallD, hz.FlushE, hz.syscall_go});
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({hz.StallD, hz.FlushE} !== 2'b00 || hz.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rstwait_run: got %b cnt %0d expected 00 cnt 0",
                     {hz.StallD, hz.FlushE}, hz.stall_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clk);
            n_chk++;
            if ({hz.StallD, hz.syscall_go} !== 2'b00) begin
                n_fail++;
                $display("FAIL rstwait_quiet_%0d: got %b expected 00", c, {hz.StallD, hz.syscall_go});
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            rst_n           = ($urandom_range(0, 99) != 0);
            hz.RsD          = 5'($urandom_range(0, 3));
            hz.RtD          = 5'($urandom_range(0, 3));
            hz.RsE          = 5'($urandom_range(0, 3));
            hz.RtE          = 5'($urandom_range(0, 3));
            hz.WriteRegE    = 5'($urandom_range(0, 3));
            hz.WriteRegM    = 5'($urandom_range(0, 3));
            hz.WriteRegW    = 5'($urandom_range(0, 3));
            hz.RegWriteE    = 1'($urandom_range(0, 1));
            hz.RegWriteM    = 1'($urandom_range(0, 1));
            hz.RegWriteW    = 1'($urandom_range(0, 1));
            hz.MemReadE     = ($urandom_range(0, 3) == 0);
            hz.MemToRegM    = ($urandom_range(0, 3) == 0);
            hz.BranchD      = ($urandom_range(0, 3) == 0);
            hz.PCSrcD       = 1'($urandom_range(0, 1));
            hz.SyscallD     = ($urandom_range(0, 7) == 0);
            hz.syscall_done = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n_chk++;
            if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go} !==
                {e_stall, e_stall, e_flushd, e_flushe, e_go}) begin
                n_fail++;
                $display("FAIL rnd_ctrl_%0d: got %b expected %b", i,
                         {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.syscall_go},
                         {e_stall, e_stall, e_flushd, e_flushe, e_go});
            end
            n_chk++;
            if ({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD} !==
                {e_fae, e_fbe, e_fad, e_fbd}) begin
                n_fail++;
                $display("FAIL rnd_fwd_%0d: got %b expected %b", i,
                         {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD},
                         {e_fae, e_fbe, e_fad, e_fbd});
            end
            n_chk++;
            if (hz.syscall_err !== m_err[0] || hz.stall_cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rnd_state_%0d: got err %b cnt %0d expected err %0d cnt %0d", i,
                         hz.syscall_err, hz.stall_cnt, m_err, m_cnt);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_syscall();
        test_timeout();
        test_syscall_hazard();
        test_reset_mid_wait();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and flush controller for the 5-stage MIPS pipeline; it drives the clr input of the decode→execute pipeline register.
- Detects load-use and branch-operand hazards and asserts stalls/flushes.
- Produces forwarding selects for the execute and decode stages.
- Sequences syscall: drain pipeline, hand off to service logic, resume.
- Sits beside the pipeline registers; all hazard decisions are made here.

Parameters:
DRAIN_CYCLES, 3, bubble cycles inserted before syscall hand-off (legal range 1..15)
SVC_TIMEOUT, 255, max WAIT_SVC cycles before forced resume with error (legal range 1..255)

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
RsD  in  5  rs field of instruction in decode
RtD  in  5  rt field of instruction in decode
RsE  in  5  rs field in execute
RtE  in  5  rt field in execute
WriteRegE  in  5  destination register in execute
WriteRegM  in  5  destination register in memory
WriteRegW  in  5  destination register in writeback
RegWriteE  in  1  reg write in execute
RegWriteM  in  1  reg write in memory
RegWriteW  in  1  reg write in writeback
MemReadE  in  1  load in execute (memread out of the ID/EX register)
MemToRegM  in  1  load in memory
BranchD  in  1  branch in decode
PCSrcD  in  1  branch taken in decode
SyscallD  in  1  syscall in decode
syscall_done  in  1  service-logic completion pulse
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (its clr)
ForwardAE  out  2  execute operand A select: 00 = regfile, 01 = writeback result, 10 = memory ALU result
ForwardBE  out  2  execute operand B select, same encoding as ForwardAE
ForwardAD  out  1  forward memory ALU result to decode comparator operand A
ForwardBD  out  1  forward memory ALU result to decode comparator operand B
syscall_go  out  1  one-cycle pulse: pipeline drained, service syscall
syscall_err  out  1  sticky: last syscall timed out
stall_cnt  out  16  saturating count of cycles with StallD=1

Behaviour:
- State (FSM, drain counter, timeout counter, syscall_err, stall_cnt) updates on posedge clk.
- When rst_n is sampled low:
  - FSM goes to RUN; all counters clear; syscall_err clears; stall_cnt = 0.
  - While rst_n is low, outputs are gated to: StallF=StallD=FlushD=0, FlushE=1, forwards=0, syscall_go=0.
- Forwarding (combinational, register 0 never forwarded):
  - ForwardAE = 10 if RsE!=0 & RegWriteM & WriteRegM==RsE.
  - Else ForwardAE = 01 if RsE!=0 & RegWriteW & WriteRegW==RsE.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rules with RtE.
  - ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD; ForwardBD is the same with RtD.
- lwstall = MemReadE & RtE!=0 & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE∈{RsD,RtD}) | (MemToRegM & WriteRegM!=0 & WriteRegM∈{RsD,RtD})).
- haz = lwstall | brstall.
- FSM states RUN, DRAIN, WAIT_SVC, RESUME:
  - RUN:
    - StallF = StallD = FlushE = haz; FlushD = PCSrcD & ~haz.
    - If SyscallD & ~haz: go to DRAIN, drain counter = DRAIN_CYCLES-1.
    - If SyscallD & haz: stay in RUN; the hazard resolves first.
  - DRAIN:
    - StallF = StallD = FlushE = 1; FlushD = 0.
    - Counter decrements each cycle; at 0, go to WAIT_SVC.
    - syscall_go = 1 on the first WAIT_SVC cycle only.
  - WAIT_SVC:
    - StallF = StallD = FlushE = 1; timeout counter increments.
    - syscall_done = 1: go to RESUME and clear syscall_err.
    - Timeout counter reaches SVC_TIMEOUT-1 without done: go to RESUME and set syscall_err.
    - If done and timeout occur in the same cycle, done wins (no error).
  - RESUME:
    - Lasts one cycle: StallF = StallD = 0, FlushD = 1, FlushE = 1.
    - Retires the syscall slot; next state RUN.
- syscall_done outside WAIT_SVC is ignored.
- Reset in any state takes effect at the next edge; pending syscall_go is not issued.
- stall_cnt increments on each cycle with StallD=1 and saturates at 16'hFFFF.
- Latency:
  - Hazard outputs are same-cycle combinational.
  - syscall_go asserts DRAIN_CYCLES+1 edges after the RUN cycle that sees SyscallD.

Test Plan:
- Load-use: MemReadE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 for 1 cycle, stall_cnt=1. Same stimulus with RtE=0 -> no stall.
- Forward priority: RsE=8, RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=10. Drop RegWriteM -> 01.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=RtD=3 -> stall, FlushD=0. Next cycle PCSrcD=1 with no hazard -> FlushD=1.
- Syscall, DRAIN_CYCLES=3:
  - SyscallD at cycle 0 -> 3 bubble cycles, syscall_go pulse at cycle 4.
  - syscall_done at cycle 6 -> RESUME at cycle 7 with FlushD=FlushE=1, RUN at cycle 8, syscall_err=0.
- Timeout, SVC_TIMEOUT=4: no syscall_done -> RESUME after 4 WAIT_SVC cycles, syscall_err=1. Next syscall completed normally -> syscall_err=0.
- Reset mid-WAIT_SVC: rst_n low one cycle -> RUN, stall_cnt=0, no syscall_go. FlushE=1 while rst_n is low.
